// File: rtl/dcpu_ctrl_if.sv
// rtl/dcpu_ctrl_if.sv - shared memory port handshake between dcpu_ctrl and memory
interface dcpu_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ifetch;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_ifetch,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_ifetch,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/dcpu_ctrl.sv
// rtl/dcpu_ctrl.sv - dcpu sequencer: fetch, decode and memory-port arbitration
module dcpu_ctrl (
  input  logic             i_clk,
  input  logic             i_reset,
  dcpu_ctrl_if.master      mem,
  input  logic [2:0]       i_flags,
  output logic [2:0]       o_addr_sel,
  output logic [3:0]       o_alu_l_sel,
  output logic [3:0]       o_alu_r_sel,
  output logic [2:0]       o_op,
  output logic [3:0]       o_load_reg_sel,
  output logic             o_load,
  output logic             o_bus_src,
  output logic             o_pc_inc,
  output logic             o_pc_load,
  output logic             o_halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] C_ALU    = 2'b00;
  localparam logic [1:0] C_LOAD   = 2'b01;
  localparam logic [1:0] C_STORE  = 2'b10;
  localparam logic [1:0] C_BRANCH = 2'b11;
  localparam logic [2:0] OP_PASS  = 3'b111;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [1:0] ir_class;
  logic [2:0] ir_op;
  logic [2:0] ir_mod;
  logic [3:0] ir_ra;
  logic [3:0] ir_rb;
  logic       is_halt;
  logic       br_taken;

  assign ir_class = ir_q[15:14];
  assign ir_op    = ir_q[13:11];
  assign ir_mod   = ir_q[10:8];
  assign ir_ra    = ir_q[7:4];
  assign ir_rb    = ir_q[3:0];
  assign is_halt  = (ir_class == C_BRANCH) && (ir_op == OP_PASS);
  // mod selects which flags qualify the branch; mod==0 is unconditional
  assign br_taken = (ir_mod == 3'd0) || ((i_flags & ir_mod) != 3'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem.mem_ack) begin
          ir_d = mem.mem_rdata;
          // classes 01 and 10 need the memory port a second time
          state_d = (mem.mem_rdata[15] ^ mem.mem_rdata[14]) ? S_MEM : S_EXEC;
        end
      end
      S_EXEC:  state_d = is_halt ? S_HALT : S_FETCH;
      S_MEM:   if (mem.mem_ack) state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_ifetch = 1'b0;
    o_addr_sel     = 3'd0;
    o_alu_l_sel    = 4'd0;
    o_alu_r_sel    = 4'd0;
    o_op           = 3'd0;
    o_load_reg_sel = 4'd0;
    o_load         = 1'b0;
    o_bus_src      = 1'b0;
    o_pc_inc       = 1'b0;
    o_pc_load      = 1'b0;
    o_halted       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.mem_req    = 1'b1;
        mem.mem_ifetch = 1'b1;
        o_pc_inc       = mem.mem_ack;
      end
      S_EXEC: begin
        if (ir_class == C_ALU) begin
          o_alu_l_sel    = ir_ra;
          o_alu_r_sel    = ir_rb;
          o_op           = ir_op;
          o_load_reg_sel = ir_ra;
          o_load         = 1'b1;
        end else if (ir_class == C_BRANCH && !is_halt && br_taken) begin
          o_addr_sel = ir_rb[2:0];
          o_pc_load  = 1'b1;
        end
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        o_addr_sel  = ir_mod;
        if (ir_class == C_STORE) begin
          mem.mem_we  = 1'b1;
          o_alu_l_sel = ir_ra;
          o_op        = OP_PASS;
        end else begin
          o_load_reg_sel = ir_ra;
          o_bus_src      = 1'b1;
          o_load         = mem.mem_ack;
        end
      end
      S_HALT:  o_halted = 1'b1;
      default: ;
    endcase
  end

endmodule
